// File: rtl/video_timing_gen_if.sv
// Timing-configuration channel of video_timing_gen: one valid/ready offer
// carrying a complete raster description, plus a one-cycle rejection pulse.
interface video_timing_gen_if #(
  parameter int W = 12
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_err;
  logic [W-1:0] cfg_h_act;
  logic [W-1:0] cfg_h_fp;
  logic [W-1:0] cfg_h_sync;
  logic [W-1:0] cfg_h_bp;
  logic [W-1:0] cfg_v_act;
  logic [W-1:0] cfg_v_fp;
  logic [W-1:0] cfg_v_sync;
  logic [W-1:0] cfg_v_bp;
  logic         cfg_hs_pol;
  logic         cfg_vs_pol;

  modport master (
    output cfg_valid,
    output cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    output cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    output cfg_hs_pol, cfg_vs_pol,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    input  cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    input  cfg_hs_pol, cfg_vs_pol,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable raster timing generator in the pixel clock domain.
// New timing is staged in a pending register and swapped in at a frame boundary.
module video_timing_gen #(
  parameter int W      = 12,
  parameter int LEAD   = 1,
  parameter int H_ACT  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_ACT  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic              clock_pixel,
  input  logic              reset,
  input  logic              enable,
  video_timing_gen_if.slave cfg,
  output logic              SYNC_H,
  output logic              SYNC_V,
  output logic              DE,
  output logic [W-1:0]      oX,
  output logic [W-1:0]      oY,
  output logic              oRequest,
  output logic              frame_start,
  output logic              line_start
);

  // Totals carry two extra bits so four W-bit fields can never overflow.
  localparam int            TW      = W + 2;
  localparam logic [TW-1:0] TOT_MAX = {2'b01, {W{1'b0}}};

  typedef struct packed {
    logic [W-1:0] h_act;
    logic [W-1:0] h_fp;
    logic [W-1:0] h_sync;
    logic [W-1:0] h_bp;
    logic [W-1:0] v_act;
    logic [W-1:0] v_fp;
    logic [W-1:0] v_sync;
    logic [W-1:0] v_bp;
    logic         hs_pol;
    logic         vs_pol;
  } timing_t;

  localparam timing_t RESET_TIMING = '{
    h_act:  W'(H_ACT),  h_fp: W'(H_FP), h_sync: W'(H_SYNC), h_bp: W'(H_BP),
    v_act:  W'(V_ACT),  v_fp: W'(V_FP), v_sync: W'(V_SYNC), v_bp: W'(V_BP),
    hs_pol: HS_POL,     vs_pol: VS_POL
  };

  function automatic logic [TW-1:0] total4(input logic [W-1:0] a, b, c, d);
    return TW'(a) + TW'(b) + TW'(c) + TW'(d);
  endfunction

  function automatic logic in_window(input logic [TW-1:0] pos, lo, len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

  function automatic logic timing_ok(input timing_t t);
    return (t.h_act != '0) && (t.v_act != '0) &&
           (t.h_sync != '0) && (t.v_sync != '0) &&
           (total4(t.h_act, t.h_fp, t.h_sync, t.h_bp) <= TOT_MAX) &&
           (total4(t.v_act, t.v_fp, t.v_sync, t.v_bp) <= TOT_MAX);
  endfunction

  timing_t       act;
  timing_t       pend_cfg;
  timing_t       offer;
  logic          pend;
  logic          take;
  logic          swap;
  logic          wrap;
  logic          hc_last;
  logic          vc_last;
  logic [W-1:0]  hc;
  logic [W-1:0]  vc;
  logic [TW-1:0] h_tot;
  logic [TW-1:0] v_tot;
  logic [TW-1:0] hc_w;
  logic [TW-1:0] vc_w;
  logic [TW-1:0] rh_raw;
  logic [TW-1:0] rh;
  logic [TW-1:0] rv;
  logic          de_p0;
  logic          hs_p0;
  logic          vs_p0;
  logic          req_p0;

  assign offer = '{
    h_act:  cfg.cfg_h_act,  h_fp: cfg.cfg_h_fp, h_sync: cfg.cfg_h_sync, h_bp: cfg.cfg_h_bp,
    v_act:  cfg.cfg_v_act,  v_fp: cfg.cfg_v_fp, v_sync: cfg.cfg_v_sync, v_bp: cfg.cfg_v_bp,
    hs_pol: cfg.cfg_hs_pol, vs_pol: cfg.cfg_vs_pol
  };

  assign h_tot   = total4(act.h_act, act.h_fp, act.h_sync, act.h_bp);
  assign v_tot   = total4(act.v_act, act.v_fp, act.v_sync, act.v_bp);
  assign hc_w    = TW'(hc);
  assign vc_w    = TW'(vc);
  assign hc_last = (hc_w == h_tot - TW'(1));
  assign vc_last = (vc_w == v_tot - TW'(1));
  assign wrap    = hc_last && vc_last;

  assign cfg.cfg_ready = !pend;
  assign take          = cfg.cfg_valid && !pend;
  // An idle raster has no frame to protect, so staged timing lands at once.
  assign swap          = pend && (!enable || wrap);

  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (!enable) begin
      hc <= '0;
      vc <= '0;
    end else if (hc_last) begin
      hc <= '0;
      vc <= vc_last ? '0 : vc + W'(1);
    end else begin
      hc <= hc + W'(1);
    end
  end

  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      act         <= RESET_TIMING;
      pend        <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= take && !timing_ok(offer);
      if (swap) begin
        act  <= pend_cfg;
        pend <= 1'b0;
      end else if (take && timing_ok(offer)) begin
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_pixel) begin
    if (take && timing_ok(offer)) begin
      pend_cfg <= offer;
    end
  end

  // Request lookahead: position LEAD pixels ahead, folding into the next line.
  assign rh_raw = hc_w + TW'(LEAD);

  always_comb begin
    rh = rh_raw;
    rv = vc_w;
    if (rh_raw >= h_tot) begin
      rh = rh_raw - h_tot;
      rv = vc_last ? '0 : vc_w + TW'(1);
    end
  end

  // p0: decode of the current counter position
  assign de_p0  = (hc < act.h_act) && (vc < act.v_act);
  assign hs_p0  = in_window(hc_w, TW'(act.h_act) + TW'(act.h_fp), TW'(act.h_sync));
  assign vs_p0  = in_window(vc_w, TW'(act.v_act) + TW'(act.v_fp), TW'(act.v_sync));
  assign req_p0 = (rh < TW'(act.h_act)) && (rv < TW'(act.v_act));

  // p1: registered outputs, one cycle behind the counters
  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      SYNC_H      <= ~HS_POL;
      SYNC_V      <= ~VS_POL;
      DE          <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oRequest    <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (!enable) begin
      SYNC_H      <= ~act.hs_pol;
      SYNC_V      <= ~act.vs_pol;
      DE          <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oRequest    <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      SYNC_H      <= ~(hs_p0 ^ act.hs_pol);
      SYNC_V      <= ~(vs_p0 ^ act.vs_pol);
      DE          <= de_p0;
      oX          <= de_p0 ? hc : '0;
      oY          <= de_p0 ? vc : '0;
      oRequest    <= req_p0;
      frame_start <= (hc == '0) && (vc == '0);
      line_start  <= (hc == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a small 14x7 raster with a 2-pixel
// request lead: raster decode, reprogramming, rejection, enable drop, reset.
module tb_video_timing_gen;

  localparam int W    = 12;
  localparam int LEAD = 2;

  logic         clock_pixel = 1'b0;
  logic         reset;
  logic         enable;
  logic         SYNC_H;
  logic         SYNC_V;
  logic         DE;
  logic [W-1:0] oX;
  logic [W-1:0] oY;
  logic         oRequest;
  logic         frame_start;
  logic         line_start;

  int n_cmp = 0;
  int n_err = 0;
  int p;
  int e_ha, e_hf, e_hs, e_hb, e_va, e_vf, e_vs, e_vb;
  bit e_hp, e_vp, e_run;
  int n_hs_low, n_de, n_fs;
  int rej [3][8] = '{'{0, 2, 2, 2, 4, 1, 1, 1},
                     '{8, 2, 2, 2, 4, 1, 0, 1},
                     '{4095, 1, 1, 0, 4, 1, 1, 1}};

  video_timing_gen_if #(.W(W)) cfg_bus ();

  video_timing_gen #(
    .W(W), .LEAD(LEAD),
    .H_ACT(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACT(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clock_pixel (clock_pixel),
    .reset       (reset),
    .enable      (enable),
    .cfg         (cfg_bus.slave),
    .SYNC_H      (SYNC_H),
    .SYNC_V      (SYNC_V),
    .DE          (DE),
    .oX          (oX),
    .oY          (oY),
    .oRequest    (oRequest),
    .frame_start (frame_start),
    .line_start  (line_start)
  );

  always #5 clock_pixel = ~clock_pixel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at p=%0d: observed %0d, expected %0d", tag, p, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_pixel);
    #1;
    p++;
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
    cfg_bus.cfg_h_act  = W'(ha);
    cfg_bus.cfg_h_fp   = W'(hf);
    cfg_bus.cfg_h_sync = W'(hs);
    cfg_bus.cfg_h_bp   = W'(hb);
    cfg_bus.cfg_v_act  = W'(va);
    cfg_bus.cfg_v_fp   = W'(vf);
    cfg_bus.cfg_v_sync = W'(vs);
    cfg_bus.cfg_v_bp   = W'(vb);
    cfg_bus.cfg_hs_pol = hp;
    cfg_bus.cfg_vs_pol = vp;
  endtask

  task automatic expect_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit hp, vp);
    e_ha = ha; e_hf = hf; e_hs = hs; e_hb = hb;
    e_va = va; e_vf = vf; e_vs = vs; e_vb = vb;
    e_hp = hp; e_vp = vp;
  endtask

  // Expected outputs for raster position p (counted from the first frame_start).
  task automatic check_pos();
    int th, tv, q, hc, vc, rh, rv, de, hsa, vsa, req;
    if (!e_run) begin
      chk("idle_de", DE, 0);
      chk("idle_ox", oX, 0);
      chk("idle_oy", oY, 0);
      chk("idle_req", oRequest, 0);
      chk("idle_fs", frame_start, 0);
      chk("idle_ls", line_start, 0);
      chk("idle_sync_h", SYNC_H, !e_hp);
      chk("idle_sync_v", SYNC_V, !e_vp);
    end else begin
      th  = e_ha + e_hf + e_hs + e_hb;
      tv  = e_va + e_vf + e_vs + e_vb;
      q   = p % (th * tv);
      hc  = q % th;
      vc  = q / th;
      de  = (hc < e_ha && vc < e_va) ? 1 : 0;
      hsa = (hc >= e_ha + e_hf && hc < e_ha + e_hf + e_hs) ? 1 : 0;
      vsa = (vc >= e_va + e_vf && vc < e_va + e_vf + e_vs) ? 1 : 0;
      rh  = hc + LEAD;
      rv  = vc;
      if (rh >= th) begin
        rh = rh - th;
        rv = (vc + 1) % tv;
      end
      req = (rh < e_ha && rv < e_va) ? 1 : 0;
      chk("de", DE, de);
      chk("ox", oX, de ? hc : 0);
      chk("oy", oY, de ? vc : 0);
      chk("sync_h", SYNC_H, (hsa == int'(e_hp)) ? 1 : 0);
      chk("sync_v", SYNC_V, (vsa == int'(e_vp)) ? 1 : 0);
      chk("req", oRequest, req);
      chk("fs", frame_start, (q == 0) ? 1 : 0);
      chk("ls", line_start, (hc == 0) ? 1 : 0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    expect_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0);
    e_run = 1'b0;
    p = 0;
    #12;
    chk("rst_de", DE, 0);
    chk("rst_sync_h", SYNC_H, 1);
    chk("rst_sync_v", SYNC_V, 1);
    chk("rst_ready", cfg_bus.cfg_ready, 1);
    chk("rst_err", cfg_bus.cfg_err, 0);
    chk("rst_ox", oX, 0);
    chk("rst_req", oRequest, 0);
    chk("rst_fs", frame_start, 0);

    // Free-running frame on the reset timing, plus the next frame_start.
    @(posedge clock_pixel);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    e_run  = 1'b1;
    p = -1;
    n_hs_low = 0; n_de = 0; n_fs = 0;
    repeat (99) begin
      step();
      check_pos();
      if (p < 98) begin
        n_hs_low += (SYNC_H === 1'b0) ? 1 : 0;
        n_de     += (DE === 1'b1) ? 1 : 0;
        n_fs     += (frame_start === 1'b1) ? 1 : 0;
      end
      if (p == 7)  chk("ox_last_pixel", oX, 7);
      if (p == 12) chk("req_lead_line1", oRequest, 1);
      if (p == 96) chk("req_next_frame", oRequest, 1);
      if (p == 98) chk("fs_period_98", frame_start, 1);
    end
    chk("hs_low_count", n_hs_low, 14);
    chk("de_count", n_de, 32);
    chk("fs_count", n_fs, 1);

    // Rejected offers: zero h_act, zero v_sync, horizontal total of 4097.
    for (int i = 0; i < 3; i++) begin
      set_cfg(rej[i][0], rej[i][1], rej[i][2], rej[i][3],
              rej[i][4], rej[i][5], rej[i][6], rej[i][7], 1'b0, 1'b0);
      cfg_bus.cfg_valid = 1'b1;
      step();
      check_pos();
      chk("rej_err", cfg_bus.cfg_err, 1);
      chk("rej_ready", cfg_bus.cfg_ready, 1);
      cfg_bus.cfg_valid = 1'b0;
      step();
      check_pos();
      chk("rej_err_clear", cfg_bus.cfg_err, 0);
      chk("rej_ready_hold", cfg_bus.cfg_ready, 1);
    end

    // Drop enable with the counter at (5,2).
    while ((p % 98) != 32) begin
      step();
      check_pos();
    end
    chk("pre_drop_de", DE, 1);
    enable = 1'b0;
    e_run  = 1'b0;
    step();
    check_pos();
    step();
    check_pos();

    // While idle, a total of exactly 4096 is accepted and swapped at once.
    set_cfg(4093, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
    cfg_bus.cfg_valid = 1'b1;
    step();
    check_pos();
    chk("max_total_err", cfg_bus.cfg_err, 0);
    chk("max_total_ready", cfg_bus.cfg_ready, 0);
    cfg_bus.cfg_valid = 1'b0;
    step();
    check_pos();
    chk("idle_swap_ready", cfg_bus.cfg_ready, 1);
    set_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0);
    cfg_bus.cfg_valid = 1'b1;
    step();
    check_pos();
    chk("restore_ready", cfg_bus.cfg_ready, 0);
    cfg_bus.cfg_valid = 1'b0;
    step();
    check_pos();
    chk("restore_swap_ready", cfg_bus.cfg_ready, 1);

    // Re-enable: frame_start one cycle after enable is sampled.
    enable = 1'b1;
    e_run  = 1'b1;
    p = -1;
    step();
    check_pos();
    chk("reenable_fs", frame_start, 1);

    // Mid-frame reprogram to 4/1/1/1 x 2/1/1/1 with active-high syncs.
    while ((p % 98) != 40) begin
      step();
      check_pos();
    end
    set_cfg(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    cfg_bus.cfg_valid = 1'b1;
    step();
    check_pos();
    chk("take_ready", cfg_bus.cfg_ready, 0);
    chk("take_err", cfg_bus.cfg_err, 0);
    set_cfg(0, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    step();
    check_pos();
    chk("ignored_err", cfg_bus.cfg_err, 0);
    chk("ignored_ready", cfg_bus.cfg_ready, 0);
    cfg_bus.cfg_valid = 1'b0;
    while ((p % 98) != 96) begin
      step();
      check_pos();
      chk("pend_ready", cfg_bus.cfg_ready, 0);
    end
    step();
    check_pos();
    chk("swap_ready", cfg_bus.cfg_ready, 1);

    expect_cfg(4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1);
    p = -1;
    n_de = 0; n_fs = 0;
    repeat (36) begin
      step();
      check_pos();
      if (p < 35) begin
        n_de += (DE === 1'b1) ? 1 : 0;
        n_fs += (frame_start === 1'b1) ? 1 : 0;
      end
      if (p == 0)  chk("new_sync_h_idle", SYNC_H, 0);
      if (p == 5)  chk("new_sync_h_active", SYNC_H, 1);
      if (p == 35) chk("new_fs_period_35", frame_start, 1);
    end
    chk("new_de_count", n_de, 8);
    chk("new_fs_count", n_fs, 1);

    // Asynchronous reset in the middle of an active line.
    step();
    check_pos();
    chk("pre_rst_de", DE, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_de", DE, 0);
    chk("arst_ox", oX, 0);
    chk("arst_sync_h", SYNC_H, 1);
    chk("arst_sync_v", SYNC_V, 1);
    chk("arst_ready", cfg_bus.cfg_ready, 1);
    chk("arst_ls", line_start, 0);
    chk("arst_req", oRequest, 0);
    @(posedge clock_pixel);
    #1;
    reset = 1'b0;
    expect_cfg(8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0);
    p = -1;
    repeat (20) begin
      step();
      check_pos();
      if (p == 0) chk("post_rst_fs", frame_start, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
